// File: rtl/trap_pkg.sv
// trap_pkg: CP0 register encodings, trap cause codes and trap controller states
package trap_pkg;
    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;
    localparam logic [1:0] SEL_STATUS = 2'd0;
    localparam logic [1:0] SEL_CAUSE  = 2'd1;
    localparam logic [1:0] SEL_EPC    = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_HANDLER = 2'd1;
    localparam logic [1:0] ST_SETTLE  = 2'd2;
    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int IM_LSB     = 8;
    localparam int IP_LSB     = 8;
    localparam int CODE_LSB   = 2;
endpackage

// File: rtl/irq_pending.sv
// irq_pending: rising-edge capture of external interrupt lines into a W1C pending vector
module irq_pending
    import trap_pkg::*;
#(
    parameter int NIRQ = 4
) (
    input  logic            Clk,
    input  logic            Clrn,
    input  logic [NIRQ-1:0] irq,
    input  logic            clr,
    input  logic [NIRQ-1:0] clr_mask,
    output logic [NIRQ-1:0] pending
);
    logic [NIRQ-1:0] irq_q;
    // irq_q tracks the lines through reset so a level held across reset is not an edge
    always_ff @(posedge Clk) begin
        irq_q <= irq;
        pending <= Clrn ? (pending & ~(clr ? clr_mask : '0)) | (irq & ~irq_q) : '0;
    end
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: status/cause/epc registers, exception priority, interrupt gating and PC redirect
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int          NIRQ     = 4,
    parameter logic [31:0] VEC_BASE = 32'h0000_0040
) (
    input  logic            Clk,
    input  logic            Clrn,
    input  logic [NIRQ-1:0] irq,
    input  logic [31:0]     pc,
    input  logic            exc_ri,
    input  logic            exc_ov,
    input  logic            exc_sys,
    input  logic            eret,
    input  logic            cp0_we,
    input  logic [1:0]      cp0_sel,
    input  logic [31:0]     cp0_wdata,
    output logic [31:0]     cp0_rdata,
    output logic            redirect,
    output logic [31:0]     redirect_pc,
    output logic            kill
);
    logic [1:0]      state;
    logic            ie;
    logic [NIRQ-1:0] im;
    logic [NIRQ-1:0] pending;
    logic [4:0]      code;
    logic [31:0]     epc;
    logic            ri, exc, eret_ok, int_take, trap, wr;
    logic [4:0]      exc_code;
    logic [31:0]     status, cause;
    logic            unused_wdata;
    assign unused_wdata = ^cp0_wdata;
    // an eret outside the handler is an illegal instruction
    always_comb begin
        ri = exc_ri | (eret & state != ST_HANDLER);
        exc = ri | exc_ov | exc_sys;
        exc_code = ri ? EXC_RI : exc_ov ? EXC_OV : EXC_SYS;
        eret_ok = eret & state == ST_HANDLER & ~exc;
        int_take = state == ST_RUN & ie & |(pending & im) & ~exc & ~eret & ~cp0_we;
        trap = exc | int_take;
        wr = cp0_we & ~trap;
        kill = Clrn & trap;
        redirect = Clrn & (trap | eret_ok);
        redirect_pc = trap ? VEC_BASE : epc;
        status = '0;
        status[STATUS_IE] = ie;
        status[STATUS_EXL] = state != ST_RUN;
        status[IM_LSB +: NIRQ] = im;
        cause = '0;
        cause[CODE_LSB +: 5] = code;
        cause[IP_LSB +: NIRQ] = pending;
        cp0_rdata = cp0_sel == SEL_STATUS ? status :
                    cp0_sel == SEL_CAUSE  ? cause  :
                    cp0_sel == SEL_EPC    ? epc    : '0;
    end
    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            state <= ST_RUN;
            ie <= 1'b0;
            im <= '0;
            code <= EXC_INT;
            epc <= '0;
        end else begin
            if (trap) begin
                state <= ST_HANDLER;
                code <= exc ? exc_code : EXC_INT;
                if (state != ST_HANDLER) epc <= pc;
            end else if (eret_ok) begin
                state <= ST_SETTLE;
            end else if (state == ST_SETTLE) begin
                state <= ST_RUN;
            end
            if (wr & cp0_sel == SEL_STATUS) begin
                ie <= cp0_wdata[STATUS_IE];
                im <= cp0_wdata[IM_LSB +: NIRQ];
            end
            if (wr & cp0_sel == SEL_EPC) epc <= cp0_wdata;
        end
    end
    irq_pending #(.NIRQ(NIRQ)) u_pending (
        .Clk      (Clk),
        .Clrn     (Clrn),
        .irq      (irq),
        .clr      (wr & cp0_sel == SEL_CAUSE),
        .clr_mask (cp0_wdata[IP_LSB +: NIRQ]),
        .pending  (pending)
    );
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed trap scenarios plus random traffic against a behavioural CP0 model
module tb_trap_ctrl;
    logic        Clk = 1'b0, Clrn = 1'b0;
    logic [3:0]  irq = 4'b0;
    logic [31:0] pc = 32'h0;
    logic        exc_ri = 1'b0, exc_ov = 1'b0, exc_sys = 1'b0, eret = 1'b0, cp0_we = 1'b0;
    logic [1:0]  cp0_sel = 2'd0;
    logic [31:0] cp0_wdata = 32'h0;
    logic [31:0] cp0_rdata, redirect_pc;
    logic        redirect, kill;
    int errors = 0, checks = 0;
    bit          m_hand = 0, m_settle = 0, m_ie = 0;
    logic [3:0]  m_im = 0, m_pend = 0, m_pirq = 0;
    logic [4:0]  m_code = 0;
    logic [31:0] m_epc = 0;

    trap_ctrl #(.NIRQ(4), .VEC_BASE(32'h0000_0040)) dut (
        .Clk(Clk), .Clrn(Clrn), .irq(irq), .pc(pc), .exc_ri(exc_ri), .exc_ov(exc_ov),
        .exc_sys(exc_sys), .eret(eret), .cp0_we(cp0_we), .cp0_sel(cp0_sel),
        .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .kill(kill)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // compare combinational outputs with the model, then clock once and advance the model
    task automatic tick();
        logic bad, ex, intr, trap, wr, exp_redir;
        logic [4:0] code;
        logic [31:0] st, ca, rd;
        #1;
        bad = eret && !m_hand;
        ex = exc_ri || bad || exc_ov || exc_sys;
        code = (exc_ri || bad) ? 5'd10 : exc_ov ? 5'd12 : 5'd8;
        intr = !m_hand && !m_settle && m_ie && (m_pend & m_im) != 0 && !ex && !eret && !cp0_we;
        trap = ex || intr;
        exp_redir = Clrn && (trap || (eret && m_hand));
        st = {20'b0, m_im, 6'b0, m_hand || m_settle, m_ie};
        ca = {20'b0, m_pend, 1'b0, m_code, 2'b0};
        rd = cp0_sel == 0 ? st : cp0_sel == 1 ? ca : cp0_sel == 2 ? m_epc : 32'h0;
        chk("redirect", {31'b0, redirect}, {31'b0, exp_redir});
        chk("kill", {31'b0, kill}, {31'b0, Clrn && trap});
        if (exp_redir) chk("redirect_pc", redirect_pc, trap ? 32'h40 : m_epc);
        if (Clrn) chk("cp0_rdata", cp0_rdata, rd);
        @(posedge Clk);
        if (!Clrn) begin
            m_hand = 0; m_settle = 0; m_ie = 0; m_im = 0; m_pend = 0; m_code = 0; m_epc = 0;
        end else begin
            wr = cp0_we && !trap;
            if (trap) begin
                if (!m_hand) m_epc = pc;
                m_code = ex ? code : 5'd0;
                m_hand = 1; m_settle = 0;
            end else if (eret && m_hand) begin
                m_hand = 0; m_settle = 1;
            end else m_settle = 0;
            if (wr && cp0_sel == 0) begin m_ie = cp0_wdata[0]; m_im = cp0_wdata[11:8]; end
            if (wr && cp0_sel == 2) m_epc = cp0_wdata;
            m_pend = (m_pend & ~((wr && cp0_sel == 1) ? cp0_wdata[11:8] : 4'b0)) | (irq & ~m_pirq);
        end
        m_pirq = irq;
        @(negedge Clk);
    endtask

    task automatic mtc0(input logic [1:0] s, input logic [31:0] d);
        cp0_we = 1; cp0_sel = s; cp0_wdata = d;
        tick();
        cp0_we = 0;
    endtask

    task automatic rdchk(input string tag, input logic [1:0] s, input logic [31:0] mask, input logic [31:0] exp);
        cp0_sel = s;
        #1;
        chk(tag, cp0_rdata & mask, exp);
    endtask

    task automatic leave_handler();
        mtc0(1, 32'h0000_0F00);
        eret = 1; tick(); eret = 0;
        tick();
    endtask

    initial begin
        irq = 4'b0001;
        tick(); tick();
        Clrn = 1;
        rdchk("rst_status", 0, 32'hFFFF_FFFF, 32'h0);
        rdchk("rst_cause", 1, 32'hFFFF_FFFF, 32'h0);
        mtc0(0, 32'h0000_0F01);
        repeat (3) tick();
        #1 chk("held_irq_no_trap", {31'b0, redirect}, 32'h0);
        irq = 4'b0011; tick();
        rdchk("ip_after_edge", 1, 32'h0000_0F00, 32'h0000_0200);
        chk("irq1_trap", {31'b0, redirect}, 32'h1);
        tick();
        leave_handler();

        mtc0(0, 32'h0000_0401);
        irq = 4'b0111; pc = 32'h20; tick();
        #1 chk("irq2_redirect", {31'b0, redirect}, 32'h1);
        chk("irq2_pc", redirect_pc, 32'h40);
        chk("irq2_kill", {31'b0, kill}, 32'h1);
        tick();
        rdchk("irq2_epc", 2, 32'hFFFF_FFFF, 32'h20);
        rdchk("irq2_code", 1, 32'h0000_007C, 32'h0);
        rdchk("irq2_exl", 0, 32'h2, 32'h2);
        exc_ov = 1; pc = 32'h44;
        #1 chk("nested_pc", redirect_pc, 32'h40);
        tick(); exc_ov = 0;
        rdchk("nested_code", 1, 32'h0000_007C, 32'd12 << 2);
        rdchk("nested_epc", 2, 32'hFFFF_FFFF, 32'h20);
        eret = 1;
        #1 chk("eret_pc", redirect_pc, 32'h20);
        chk("eret_kill", {31'b0, kill}, 32'h0);
        tick(); eret = 0;
        #1 chk("settle_blocks", {31'b0, redirect}, 32'h0);
        tick();
        #1 chk("after_settle_trap", {31'b0, redirect}, 32'h1);
        tick();
        leave_handler();

        pc = 32'h30; exc_ri = 1; exc_sys = 1; tick(); exc_ri = 0; exc_sys = 0;
        rdchk("ri_over_sys", 1, 32'h0000_007C, 32'd10 << 2);
        eret = 1; tick(); eret = 0; tick();
        pc = 32'h10; eret = 1; tick(); eret = 0;
        rdchk("eret_run_code", 1, 32'h0000_007C, 32'd10 << 2);
        rdchk("eret_run_epc", 2, 32'hFFFF_FFFF, 32'h10);
        eret = 1; tick(); eret = 0; tick();

        irq = 4'b0011; tick();
        irq = 4'b0111; mtc0(1, 32'h0000_0400);
        rdchk("set_beats_clear", 1, 32'h0000_0400, 32'h0000_0400);
        tick();
        Clrn = 0; exc_ov = 1;
        #1 chk("rst_no_redirect", {31'b0, redirect}, 32'h0);
        tick(); Clrn = 1; exc_ov = 0;
        rdchk("rst2_status", 0, 32'hFFFF_FFFF, 32'h0);
        rdchk("rst2_cause", 1, 32'hFFFF_FFFF, 32'h0);
        rdchk("rst2_epc", 2, 32'hFFFF_FFFF, 32'h0);
        #1 chk("rst2_redirect", {31'b0, redirect}, 32'h0);

        for (int i = 0; i < 400; i++) begin
            Clrn = ($urandom_range(63) != 0);
            irq = 4'($urandom);
            pc = $urandom & 32'hFFFF_FFFC;
            exc_ri = ($urandom_range(19) == 0);
            exc_ov = ($urandom_range(19) == 0);
            exc_sys = ($urandom_range(19) == 0);
            eret = ($urandom_range(4) == 0);
            cp0_we = ($urandom_range(5) == 0);
            cp0_sel = 2'($urandom);
            cp0_wdata = $urandom;
            tick();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Exception/interrupt controller for the single-cycle CPU core. Holds the status, cause and EPC registers.
- Latches external interrupt edges and prioritises synchronous exceptions reported by the core.
- Drives a same-cycle PC redirect plus a write-kill into the core's next-PC mux.
- Instantiated in the CPU top level, next to the core, instruction memory and data memory.

Parameters:
NIRQ, 4, number of external interrupt lines (1..8)
VEC_BASE, 32'h0000_0040, handler entry address for every trap

Ports:
Clk  in  1  system clock, all state updates on rising edge
Clrn  in  1  reset, synchronous active-low
irq  in  NIRQ  external interrupt lines, rising-edge sensitive
pc  in  32  address of the instruction executing this cycle
exc_ri  in  1  reserved/unimplemented instruction this cycle
exc_ov  in  1  arithmetic overflow this cycle
exc_sys  in  1  syscall this cycle
eret  in  1  eret decoded this cycle
cp0_we  in  1  mtc0 write strobe
cp0_sel  in  2  0=status 1=cause 2=epc 3=reserved
cp0_wdata  in  32  mtc0 data
cp0_rdata  out  32  mfc0 data, combinational on cp0_sel; sel 3 reads 0
redirect  out  1  next PC must be redirect_pc
redirect_pc  out  32  VEC_BASE on trap, epc on eret
kill  out  1  suppress register-file and Wmem writes of current instruction

Behaviour:
- Reset (Clrn=0 at edge):
  - state=RUN; status=0 (IE=0, EXL=0, IM=0); cause=0; epc=0; pending=0.
  - irq_q loads irq, so a line held high across reset does not create a pending bit.
  - redirect/kill are 0 while Clrn=0.
- Register layout:
  - status: bit0 IE, bit1 EXL (read-only, mirrors state!=RUN), bits[8+NIRQ-1:8] IM.
  - cause: bits[6:2] ExcCode, bits[8+NIRQ-1:8] IP = pending. All other bits read 0.
- Edge capture:
  - irq_q<=irq every cycle; pending[i] sets on irq[i]&~irq_q[i].
  - A cause write clears pending bits written 1 (W1C). Set beats clear in the same cycle. ExcCode is not software-writable.
  - Latency: irq rises before edge k; pending visible after edge k; the earliest interrupt trap is in the cycle after edge k.
- States:
  - RUN: normal execution.
  - HANDLER: EXL=1.
  - SETTLE: one cycle after eret, interrupts blocked to guarantee the first returned instruction completes.
- Exception (combinational, any state):
  - Priority ri > ov > sys.
  - Effect: kill=1, redirect=1, redirect_pc=VEC_BASE.
  - At the edge, ExcCode<= 10/12/8 respectively. epc<=pc only when state!=HANDLER (nested exception keeps the original epc). state<=HANDLER.
- eret:
  - In HANDLER: redirect=1, redirect_pc=epc, kill=0; state<=SETTLE.
  - In RUN or SETTLE: treated as exc_ri.
- Interrupt:
  - Taken when state==RUN & IE & |(pending&IM) & no exception & ~eret & ~cp0_we.
  - Effect: kill=1, redirect=1, redirect_pc=VEC_BASE; epc<=pc, ExcCode<=0, state<=HANDLER. Pending bits are not cleared by hardware.
- SETTLE -> RUN unconditionally next edge. An exception in SETTLE is taken normally.
- mtc0:
  - If the instruction is killed, the write is suppressed.
  - Otherwise the write takes effect at the edge. A status write is visible to the interrupt check the following cycle.
- HANDLER: interrupts masked regardless of IE; pending keeps accumulating.

Decomposition:
- Package trap_pkg: ExcCode constants (INT=0, SYS=8, RI=10, OV=12), cp0_sel encodings, state enum {RUN, HANDLER, SETTLE}, status/cause bit positions.
- One sub-module irq_pending: irq_q register, edge detect, W1C pending vector, reset tracking. Parameterised by NIRQ.

Test Plan:
- Reset with irq=4'b0001 held high, then IE=1/IM=all -> no trap ever; a subsequent 0->1 on irq[1] sets IP=0b0010 and traps next cycle.
- irq[2] rises, status=32'h0000_0401 (IE, IM[2]), pc=0x20 -> redirect=1, redirect_pc=0x40, kill=1; then epc=0x20, ExcCode=0, EXL=1.
- In HANDLER: exc_ov at pc=0x44 -> redirect to 0x40, ExcCode=12, epc stays 0x20. Then eret -> redirect_pc=0x20, next cycle SETTLE with pending still set -> no trap; trap fires the cycle after.
- exc_ri and exc_sys in the same cycle -> ExcCode=10. eret while in RUN at pc=0x10 -> ExcCode=10, epc=0x10.
- mtc0 cause with cp0_wdata=32'h0000_0400 in the same cycle irq[2] rises -> pending[2] remains 1.
- Clrn=0 while in HANDLER -> next cycle state=RUN, status=cause=epc=0, redirect=0.
